// File: rtl/alarm_mode_controller.sv
// Alarm clock mode sequencer: arbitrates button pulses, edits time/alarm, drives ringing.
// Optional inactivity timeout back to CLOCK is built when MODE_TIMEOUT_EN is defined.
module alarm_mode_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] btn_pulse,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic       alarm_fire,
    output logic [2:0] mode,
    output logic [4:0] edit_hour,
    output logic [5:0] edit_min,
    output logic       time_load,
    output logic [4:0] alarm_hour,
    output logic [5:0] alarm_min,
    output logic       alarm_en,
    output logic       buzzer
);
    typedef enum logic [2:0] {
        CLOCK  = 3'd0,
        SET_TH = 3'd1,
        SET_TM = 3'd2,
        SET_AH = 3'd3,
        SET_AM = 3'd4,
        RING   = 3'd5
    } state_t;

    state_t     state;
    logic       rering_guard;
    logic       any_btn_c;
    logic       timeout_c;
    logic [4:0] hour_up_c;
    logic [4:0] hour_dn_c;
    logic [5:0] min_up_c;
    logic [5:0] min_dn_c;

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be nonzero");
    end

    assign mode      = 3'(state);
    assign any_btn_c = |btn_pulse;

    // Wrapping edit arithmetic: hours mod 24, minutes mod 60.
    assign hour_up_c = (edit_hour == 5'd23) ? 5'd0  : edit_hour + 5'd1;
    assign hour_dn_c = (edit_hour == 5'd0)  ? 5'd23 : edit_hour - 5'd1;
    assign min_up_c  = (edit_min  == 6'd59) ? 6'd0  : edit_min + 6'd1;
    assign min_dn_c  = (edit_min  == 6'd0)  ? 6'd59 : edit_min - 6'd1;

`ifdef MODE_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CW-1:0] idle_cnt;

    // Quiet-cycle counter; CLOCK holds it at zero so every state entry starts fresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (state == CLOCK || any_btn_c || timeout_c) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + CW'(1);
        end
    end

    assign timeout_c = (state != CLOCK) && !any_btn_c &&
                       (idle_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_c = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= CLOCK;
            edit_hour    <= '0;
            edit_min     <= '0;
            time_load    <= 1'b0;
            alarm_hour   <= '0;
            alarm_min    <= '0;
            alarm_en     <= 1'b0;
            buzzer       <= 1'b0;
            rering_guard <= 1'b0;
        end else begin
            time_load <= 1'b0;
            // A low sample of alarm_fire re-arms ringing; leaving RING overrides below.
            if (!alarm_fire) rering_guard <= 1'b0;

            if (timeout_c) begin
                state  <= CLOCK;
                buzzer <= 1'b0;
                if (state == RING) rering_guard <= 1'b1;
            end else begin
                unique case (state)
                    CLOCK: begin
                        if (alarm_fire && alarm_en && !rering_guard) begin
                            state  <= RING;
                            buzzer <= 1'b1;
                        end else if (btn_pulse[4]) begin
                            state     <= SET_TH;
                            edit_hour <= cur_hour;
                            edit_min  <= cur_min;
                        end else if (btn_pulse[3]) begin
                            alarm_en <= !alarm_en;
                        end else if (btn_pulse[2:0] == 3'b001) begin
                            state     <= SET_AH;
                            edit_hour <= alarm_hour;
                            edit_min  <= alarm_min;
                        end
                    end
                    SET_TH, SET_AH: begin
                        if (btn_pulse[4]) begin
                            state <= CLOCK;
                            if (state == SET_TH) begin
                                time_load <= 1'b1;
                            end else begin
                                alarm_hour <= edit_hour;
                                alarm_min  <= edit_min;
                            end
                        end else if (btn_pulse[3]) begin
                            edit_hour <= hour_up_c;
                        end else if (btn_pulse[2]) begin
                            edit_hour <= hour_dn_c;
                        end else if (|btn_pulse[1:0]) begin
                            state <= (state == SET_TH) ? SET_TM : SET_AM;
                        end
                    end
                    SET_TM, SET_AM: begin
                        if (btn_pulse[4]) begin
                            state <= CLOCK;
                            if (state == SET_TM) begin
                                time_load <= 1'b1;
                            end else begin
                                alarm_hour <= edit_hour;
                                alarm_min  <= edit_min;
                            end
                        end else if (btn_pulse[3]) begin
                            edit_min <= min_up_c;
                        end else if (btn_pulse[2]) begin
                            edit_min <= min_dn_c;
                        end else if (|btn_pulse[1:0]) begin
                            state <= (state == SET_TM) ? SET_TH : SET_AH;
                        end
                    end
                    RING: begin
                        if (any_btn_c) begin
                            state        <= CLOCK;
                            buzzer       <= 1'b0;
                            rering_guard <= 1'b1;
                        end
                    end
                    default: begin
                        state  <= CLOCK;
                        buzzer <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
